// File: rtl/cordic_ci.sv
// cordic_ci: Nios II multi-cycle custom instruction around an iterative
// rotation-mode CORDIC engine.
//   n=0 : start sin/cos of the Q16.16 angle on dataa (done after ITERATIONS+1 edges)
//   n=1 : read back cosine, n=2 : read back sine, other opcodes read 0
// Optional feature: define CORDIC_QUADRANT_EN to pre-rotate by +/-pi/2 at load,
// extending the usable angle range to +/-pi.
// reset is asynchronous and active-low.
module cordic_ci #(
    parameter int ITERATIONS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [7:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [31:0] K_GAIN  = 32'sd39797;   // 0.607253 in Q16.16
    localparam logic signed [31:0] HALF_PI = 32'sd102944;  // pi/2 in Q16.16
    localparam logic [4:0]         LAST    = 5'(ITERATIONS);

    state_t             state, state_nxt;
    logic [4:0]         iter;
    logic signed [31:0] x, y, z;
    logic signed [31:0] x_nxt, y_nxt, z_nxt;
    logic signed [31:0] cos_reg, sin_reg;
    logic [31:0]        rd_data;
    logic               unused_datab;

    // datab carries no information for this instruction
    assign unused_datab = ^datab;

    // arctangent of 2^-idx in Q16.16
    function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'sd51472;
            5'd1:    atan_lut = 32'sd30386;
            5'd2:    atan_lut = 32'sd16055;
            5'd3:    atan_lut = 32'sd8150;
            5'd4:    atan_lut = 32'sd4091;
            5'd5:    atan_lut = 32'sd2047;
            5'd6:    atan_lut = 32'sd1024;
            5'd7:    atan_lut = 32'sd512;
            5'd8:    atan_lut = 32'sd256;
            5'd9:    atan_lut = 32'sd128;
            5'd10:   atan_lut = 32'sd64;
            5'd11:   atan_lut = 32'sd32;
            5'd12:   atan_lut = 32'sd16;
            5'd13:   atan_lut = 32'sd8;
            5'd14:   atan_lut = 32'sd4;
            5'd15:   atan_lut = 32'sd2;
            default: atan_lut = 32'sd0;
        endcase
    endfunction

    // state register; clk_en freezes the FSM
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset)      state <= IDLE;
        else if (clk_en) state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (n == 8'd0) ? RUN : DONE;
            RUN:     if (iter == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: done is high for the single cycle spent in DONE
    always_comb begin
        done = (state == DONE);
    end

    // one micro-rotation: rotate toward z=0 with arithmetic shifts, 32-bit wrap
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        z_nxt = z;
        if (!z[31]) begin
            x_nxt = x - (y >>> iter);
            y_nxt = y + (x >>> iter);
            z_nxt = z - atan_lut(iter);
        end else begin
            x_nxt = x + (y >>> iter);
            y_nxt = y - (x >>> iter);
            z_nxt = z + atan_lut(iter);
        end
    end

    // read-back mux for non-compute opcodes
    always_comb begin
        case (n)
            8'd1:    rd_data = cos_reg;
            8'd2:    rd_data = sin_reg;
            default: rd_data = 32'd0;
        endcase
    end

    // datapath: load, iterate, capture results and the read response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            iter    <= '0;
            cos_reg <= '0;
            sin_reg <= '0;
            result  <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start && n == 8'd0) begin
                        iter <= '0;
`ifdef CORDIC_QUADRANT_EN
                        if ($signed(dataa) > HALF_PI) begin
                            x <= '0;
                            y <= K_GAIN;
                            z <= $signed(dataa) - HALF_PI;
                        end else if ($signed(dataa) < -HALF_PI) begin
                            x <= '0;
                            y <= -K_GAIN;
                            z <= $signed(dataa) + HALF_PI;
                        end else begin
                            x <= K_GAIN;
                            y <= '0;
                            z <= $signed(dataa);
                        end
`else
                        x <= K_GAIN;
                        y <= '0;
                        z <= $signed(dataa);
`endif
                    end else if (start) begin
                        result <= rd_data;
                    end
                end
                RUN: begin
                    if (iter == LAST) begin
                        cos_reg <= x;
                        sin_reg <= y;
                        result  <= '0;
                    end else begin
                        x    <= x_nxt;
                        y    <= y_nxt;
                        z    <= z_nxt;
                        iter <= iter + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_ci.sv
// tb_cordic_ci: directed test of the CORDIC custom instruction.
// Stimulus pushes the expected result of every done into a scoreboard queue;
// a monitor on the falling edge pops and compares whenever done is high.
// Latency is counted in rising edges after the edge that samples start.
module tb_cordic_ci;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  n = '0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    exp;
        int    tol;
    } exp_t;

    exp_t sb[$];

    cordic_ci #(.ITERATIONS(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input string name, input int exp, input int tol);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        e.tol  = tol;
        sb.push_back(e);
    endtask

    // called 1 time unit after a rising edge; returns 1 time unit after the start edge
    task automatic start_op(input logic [7:0] op, input logic [31:0] a);
        n     = op;
        dataa = a;
        datab = $urandom;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 8'd0;
        dataa = '0;
    endtask

    // counts rising edges from 'base' until done is seen, with a bounded budget
    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (!done && lat < base + 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [7:0] op, input logic [31:0] a,
                         input int exp_res, input int tol, input int exp_lat);
        int lat;
        push_exp(name, exp_res, tol);
        start_op(op, a);
        wait_done(0, lat);
        check({name, "_latency"}, lat == exp_lat, lat, exp_lat);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset && done) begin
            check("spurious_done", sb.size() != 0, 1, 0);
            if (sb.size() != 0) begin
                exp_t e;
                int   diff;
                e    = sb.pop_front();
                diff = $signed(result) - e.exp;
                check(e.name, (diff <= e.tol) && (diff >= -e.tol), $signed(result), e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;

        // reset held for three cycles
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_done", done == 1'b0, int'(done), 0);
        check("reset_result", result == 32'd0, int'(result), 0);
        do_op("rd_cos_after_reset", 8'd1, 32'd0, 0, 0, 0);

        // 16000 = 0.24414 rad
        do_op("cmp_16000", 8'd0, 32'd16000, 0, 0, 17);
        do_op("cos_16000", 8'd1, 32'd0, 63593, 4, 0);
        do_op("sin_16000", 8'd2, 32'd0, 15841, 4, 0);

        // zero angle
        do_op("cmp_0", 8'd0, 32'd0, 0, 0, 17);
        do_op("cos_0", 8'd1, 32'd0, 65536, 4, 0);
        do_op("sin_0", 8'd2, 32'd0, 0, 4, 0);

        // -pi/4
        do_op("cmp_m45", 8'd0, -32'sd51472, 0, 0, 17);
        do_op("cos_m45", 8'd1, 32'd0, 46341, 4, 0);
        do_op("sin_m45", 8'd2, 32'd0, -46341, 4, 0);

        // +pi/2, edge of the valid range
        do_op("cmp_p90", 8'd0, 32'd102944, 0, 0, 17);
        do_op("cos_p90", 8'd1, 32'd0, 0, 4, 0);
        do_op("sin_p90", 8'd2, 32'd0, 65536, 4, 0);

        // reserved opcode
        do_op("rd_op7", 8'd7, 32'd0, 0, 0, 0);

        // clk_en low for 5 edges mid-RUN stretches latency by exactly 5
        push_exp("cmp_clken", 0, 0);
        start_op(8'd0, 32'd16000);
        repeat (4) @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clk_en = 1'b1;
        wait_done(9, lat);
        check("cmp_clken_latency", lat == 22, lat, 22);
        @(posedge clk);
        #1;
        do_op("cos_clken", 8'd1, 32'd0, 63593, 4, 0);
        do_op("sin_clken", 8'd2, 32'd0, 15841, 4, 0);

        // a second compute request during RUN is dropped
        push_exp("cmp_ignore", 0, 0);
        start_op(8'd0, -32'sd51472);
        repeat (5) @(posedge clk);
        #1;
        start_op(8'd0, 32'd0);
        wait_done(6, lat);
        check("cmp_ignore_latency", lat == 17, lat, 17);
        @(posedge clk);
        #1;
        do_op("cos_ignore", 8'd1, 32'd0, 46341, 4, 0);
        do_op("sin_ignore", 8'd2, 32'd0, -46341, 4, 0);

        // reset mid-RUN aborts without a done and clears the results
        start_op(8'd0, 32'd16000);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_no_done", seen == 0, seen, 0);
        do_op("cos_after_abort", 8'd1, 32'd0, 0, 0, 0);
        do_op("sin_after_abort", 8'd2, 32'd0, 0, 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size() == 0, sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
